// File: rtl/rf68000_nic_arbiter.sv
// rf68000_nic_arbiter
//   Shares one ring NIC slave port among NREQ local bus masters.
//   Round-robin arbitration; a grant is held for the whole bus cycle.
//   A per-cycle timeout turns a lost ring response into err, and burst-read
//   asynchronous acknowledges (aack/atag) are routed back to the issuing
//   requester through a 16-entry outstanding-tag table indexed by adr[3:0].
//
// Ports
//   clk_i, rst_ni             clock, asynchronous active-low reset
//   r_cyc_i/stb_i/we_i        per-requester bus cycle controls      [NREQ]
//   r_cti_i/sel_i/adr_i/dat_i per-requester cycle type/selects/addr/data
//   r_ack_o/rty_o/err_o       per-requester responses               [NREQ]
//   r_aack_o, r_atag_o        async-ack pulse to owning requester and its tag
//   r_dat_o                   shared read data (qualify with ack/aack)
//   n_cyc_o..n_dat_o          registered request toward the NIC slave
//   n_ack_i..n_dat_i          NIC responses (sync ack/rty/err, async aack/atag)
//   gnt_o                     one-hot current grant
//   stray_o                   pulse: aack with no valid table entry
module rf68000_nic_arbiter #(
    parameter int NREQ = 4,
    parameter int TMO  = 1023
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NREQ-1:0]      r_cyc_i,
    input  logic [NREQ-1:0]      r_stb_i,
    input  logic [NREQ-1:0]      r_we_i,
    input  logic [3*NREQ-1:0]    r_cti_i,
    input  logic [4*NREQ-1:0]    r_sel_i,
    input  logic [32*NREQ-1:0]   r_adr_i,
    input  logic [32*NREQ-1:0]   r_dat_i,
    output logic [NREQ-1:0]      r_ack_o,
    output logic [NREQ-1:0]      r_rty_o,
    output logic [NREQ-1:0]      r_err_o,
    output logic [NREQ-1:0]      r_aack_o,
    output logic [31:0]          r_dat_o,
    output logic [3:0]           r_atag_o,
    output logic                 n_cyc_o,
    output logic                 n_stb_o,
    output logic                 n_we_o,
    output logic [2:0]           n_cti_o,
    output logic [3:0]           n_sel_o,
    output logic [31:0]          n_adr_o,
    output logic [31:0]          n_dat_o,
    input  logic                 n_ack_i,
    input  logic                 n_rty_i,
    input  logic                 n_err_i,
    input  logic                 n_aack_i,
    input  logic [3:0]           n_atag_i,
    input  logic [31:0]          n_dat_i,
    output logic [NREQ-1:0]      gnt_o,
    output logic                 stray_o
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, TERM} state_t;
    typedef enum logic [1:0] {RSP_NONE, RSP_ACK, RSP_ERR, RSP_RTY} rsp_t;

    // Burst reads complete asynchronously and therefore own a tag.
    function automatic logic is_burst_read(input logic we, input logic [2:0] cti);
        return !we && (cti == 3'b001 || cti == 3'b111);
    endfunction

    state_t            state_q, state_d;
    rsp_t              rsp_q, rsp_d;
    logic [IW-1:0]     gidx_q, gidx_d, rr_q, rr_d;
    logic [NREQ-1:0]   gnt_d;
    logic [9:0]        tmo_q, tmo_d;
    logic              ack_pend_q, ack_pend_d;
    logic [31:0]       rdat_q, rdat_d;
    logic              n_cyc_d, n_stb_d, n_we_d;
    logic [2:0]        n_cti_d;
    logic [3:0]        n_sel_d;
    logic [31:0]       n_adr_d, n_dat_d;
    logic [15:0]       tag_vld_q, tag_vld_d;
    logic [IW-1:0]     tag_own_q [16];
    logic              own_we;
    logic [NREQ-1:0]   elig;
    logic              win_vld;
    logic [IW-1:0]     win_idx, cand;
    logic              aack_hit, rsp_done;

    // A burst read whose tag is still outstanding must wait for its aack.
    always_comb begin
        elig = '0;
        for (int i = 0; i < NREQ; i++) begin
            elig[i] = r_cyc_i[i] && r_stb_i[i] &&
                      !(is_burst_read(r_we_i[i], r_cti_i[3*i +: 3]) &&
                        tag_vld_q[r_adr_i[32*i +: 4]]);
        end
    end

    // Scan from rr+1 upward; iterating downward lets the nearest candidate win.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = IW'((int'(rr_q) + k) % NREQ);
            if (elig[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d    = state_q;
        rsp_d      = rsp_q;
        gidx_d     = gidx_q;
        gnt_d      = gnt_o;
        rr_d       = rr_q;
        tmo_d      = tmo_q;
        ack_pend_d = ack_pend_q;
        rdat_d     = rdat_q;
        n_cyc_d    = n_cyc_o;
        n_stb_d    = n_stb_o;
        n_we_d     = n_we_o;
        n_cti_d    = n_cti_o;
        n_sel_d    = n_sel_o;
        n_adr_d    = n_adr_o;
        n_dat_d    = n_dat_o;
        tag_vld_d  = tag_vld_q;
        own_we     = 1'b0;
        rsp_done   = 1'b0;
        r_ack_o    = '0;
        r_rty_o    = '0;
        r_err_o    = '0;
        r_aack_o   = '0;
        r_atag_o   = '0;
        r_dat_o    = '0;
        stray_o    = 1'b0;

        // Async acks are independent of the FSM; the clear comes before any
        // set below so that a same-cycle set of the same tag wins.
        aack_hit = n_aack_i && tag_vld_q[n_atag_i];
        if (n_aack_i) begin
            if (aack_hit) begin
                r_aack_o[tag_own_q[n_atag_i]] = 1'b1;
                r_atag_o                      = n_atag_i;
                tag_vld_d[n_atag_i]           = 1'b0;
            end else begin
                stray_o = 1'b1;
            end
        end

        unique case (state_q)
            IDLE: begin
                ack_pend_d = 1'b0;
                tmo_d      = '0;
                if (win_vld) begin
                    gidx_d  = win_idx;
                    gnt_d   = NREQ'(1) << win_idx;
                    n_cyc_d = 1'b1;
                    n_stb_d = 1'b1;
                    n_we_d  = r_we_i[win_idx];
                    n_cti_d = r_cti_i[3*win_idx +: 3];
                    n_sel_d = r_sel_i[4*win_idx +: 4];
                    n_adr_d = r_adr_i[32*win_idx +: 32];
                    n_dat_d = r_dat_i[32*win_idx +: 32];
                    state_d = BUSY;
                end
            end
            BUSY: begin
                tmo_d = tmo_q + 10'd1;
                if (!r_cyc_i[gidx_q]) begin
                    // Requester abandoned the cycle: no response is given.
                    n_cyc_d    = 1'b0;
                    n_stb_d    = 1'b0;
                    gnt_d      = '0;
                    rr_d       = gidx_q;
                    tmo_d      = '0;
                    ack_pend_d = 1'b0;
                    state_d    = IDLE;
                end else if (n_ack_i || ack_pend_q) begin
                    // r_dat_o belongs to a coincident aack, so the sync ack waits a cycle.
                    if (n_aack_i) begin
                        ack_pend_d = 1'b1;
                    end else begin
                        r_ack_o[gidx_q] = 1'b1;
                        r_dat_o         = n_dat_i;
                        rdat_d          = n_dat_i;
                        rsp_d           = RSP_ACK;
                        ack_pend_d      = 1'b0;
                        rsp_done        = 1'b1;
                        if (is_burst_read(n_we_o, n_cti_o)) begin
                            tag_vld_d[n_adr_o[3:0]] = 1'b1;
                            own_we                  = 1'b1;
                        end
                    end
                end else if (n_err_i || tmo_q == 10'(TMO)) begin
                    r_err_o[gidx_q] = 1'b1;
                    rsp_d           = RSP_ERR;
                    rsp_done        = 1'b1;
                end else if (n_rty_i) begin
                    r_rty_o[gidx_q] = 1'b1;
                    rsp_d           = RSP_RTY;
                    rsp_done        = 1'b1;
                end
                if (rsp_done) begin
                    n_cyc_d = 1'b0;
                    n_stb_d = 1'b0;
                    rr_d    = gidx_q;
                    tmo_d   = '0;
                    state_d = TERM;
                end
            end
            TERM: begin
                if (r_cyc_i[gidx_q] && r_stb_i[gidx_q]) begin
                    r_ack_o[gidx_q] = (rsp_q == RSP_ACK);
                    r_err_o[gidx_q] = (rsp_q == RSP_ERR);
                    r_rty_o[gidx_q] = (rsp_q == RSP_RTY);
                    if (rsp_q == RSP_ACK) r_dat_o = rdat_q;
                end else begin
                    gnt_d   = '0;
                    rsp_d   = RSP_NONE;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (aack_hit) r_dat_o = n_dat_i;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            rsp_q      <= RSP_NONE;
            gidx_q     <= '0;
            gnt_o      <= '0;
            rr_q       <= '0;
            tmo_q      <= '0;
            ack_pend_q <= 1'b0;
            rdat_q     <= '0;
            n_cyc_o    <= 1'b0;
            n_stb_o    <= 1'b0;
            n_we_o     <= 1'b0;
            n_cti_o    <= '0;
            n_sel_o    <= '0;
            n_adr_o    <= '0;
            n_dat_o    <= '0;
            tag_vld_q  <= '0;
        end else begin
            state_q    <= state_d;
            rsp_q      <= rsp_d;
            gidx_q     <= gidx_d;
            gnt_o      <= gnt_d;
            rr_q       <= rr_d;
            tmo_q      <= tmo_d;
            ack_pend_q <= ack_pend_d;
            rdat_q     <= rdat_d;
            n_cyc_o    <= n_cyc_d;
            n_stb_o    <= n_stb_d;
            n_we_o     <= n_we_d;
            n_cti_o    <= n_cti_d;
            n_sel_o    <= n_sel_d;
            n_adr_o    <= n_adr_d;
            n_dat_o    <= n_dat_d;
            tag_vld_q  <= tag_vld_d;
        end
    end

    // NOTE: owner fields are storage without reset; they are only read when the valid bit is set.
    always_ff @(posedge clk_i) begin
        if (own_we) tag_own_q[n_adr_o[3:0]] <= gidx_q;
    end

endmodule

// File: tb/tb_rf68000_nic_arbiter.sv
// tb_rf68000_nic_arbiter
//   Directed self-checking bench for rf68000_nic_arbiter (NREQ=4, TMO=1023).
//   Inputs change 1 time unit after the rising edge; outputs are compared
//   1 more unit later, well away from the next edge.
module tb_rf68000_nic_arbiter;

    localparam int NREQ = 4;
    localparam int TMO  = 1023;

    logic                clk;
    logic                rst_n;
    logic [NREQ-1:0]     r_cyc, r_stb, r_we;
    logic [3*NREQ-1:0]   r_cti;
    logic [4*NREQ-1:0]   r_sel;
    logic [32*NREQ-1:0]  r_adr, r_dat;
    logic [NREQ-1:0]     r_ack, r_rty, r_err, r_aack;
    logic [31:0]         r_rdat;
    logic [3:0]          r_atag;
    logic                n_cyc, n_stb, n_we;
    logic [2:0]          n_cti;
    logic [3:0]          n_sel;
    logic [31:0]         n_adr, n_wdat;
    logic                n_ack, n_rty, n_err, n_aack;
    logic [3:0]          n_atag;
    logic [31:0]         n_rdat;
    logic [NREQ-1:0]     gnt;
    logic                stray;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc_cnt;
    int order [5] = '{1, 2, 3, 0, 1};

    rf68000_nic_arbiter #(.NREQ(NREQ), .TMO(TMO)) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .r_cyc_i  (r_cyc),
        .r_stb_i  (r_stb),
        .r_we_i   (r_we),
        .r_cti_i  (r_cti),
        .r_sel_i  (r_sel),
        .r_adr_i  (r_adr),
        .r_dat_i  (r_dat),
        .r_ack_o  (r_ack),
        .r_rty_o  (r_rty),
        .r_err_o  (r_err),
        .r_aack_o (r_aack),
        .r_dat_o  (r_rdat),
        .r_atag_o (r_atag),
        .n_cyc_o  (n_cyc),
        .n_stb_o  (n_stb),
        .n_we_o   (n_we),
        .n_cti_o  (n_cti),
        .n_sel_o  (n_sel),
        .n_adr_o  (n_adr),
        .n_dat_o  (n_wdat),
        .n_ack_i  (n_ack),
        .n_rty_i  (n_rty),
        .n_err_i  (n_err),
        .n_aack_i (n_aack),
        .n_atag_i (n_atag),
        .n_dat_i  (n_rdat),
        .gnt_o    (gnt),
        .stray_o  (stray)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_req(input int i, input logic we, input logic [2:0] cti,
                           input logic [31:0] adr, input logic [31:0] dat);
        r_cyc = r_cyc | (4'b0001 << i);
        r_stb = r_stb | (4'b0001 << i);
        if (we) r_we = r_we | (4'b0001 << i);
        else    r_we = r_we & ~(4'b0001 << i);
        r_cti[3*i +: 3]  = cti;
        r_sel[4*i +: 4]  = 4'hF;
        r_adr[32*i +: 32] = adr;
        r_dat[32*i +: 32] = dat;
    endtask

    task automatic drop_req(input int i);
        r_cyc = r_cyc & ~(4'b0001 << i);
        r_stb = r_stb & ~(4'b0001 << i);
    endtask

    // Ack the current cycle of requester i, then let it release and return to IDLE.
    task automatic do_ack(input int i);
        n_ack = 1'b1;
        settle();
        check("ack_route", {28'd0, r_ack}, 32'd1 << i);
        tick();
        n_ack = 1'b0;
        drop_req(i);
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n  = 1'b0;
        r_cyc  = '0; r_stb = '0; r_we = '0; r_cti = '0; r_sel = '0; r_adr = '0; r_dat = '0;
        n_ack  = 1'b0; n_rty = 1'b0; n_err = 1'b0; n_aack = 1'b0; n_atag = '0; n_rdat = '0;
        #2;
        check("rst_gnt",   {28'd0, gnt}, 32'd0);
        check("rst_ncyc",  {31'd0, n_cyc}, 32'd0);
        check("rst_rack",  {28'd0, r_ack}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Single write from req0, acked 5 cycles after it appears on the NIC.
        set_req(0, 1'b1, 3'b000, 32'hC010_0000, 32'h1234_5678);
        settle();
        check("w_gnt_pre", {28'd0, gnt}, 32'd0);
        tick();
        check("w_gnt",  {28'd0, gnt}, 32'h1);
        check("w_ncyc", {31'd0, n_cyc}, 32'd1);
        check("w_nwe",  {31'd0, n_we}, 32'd1);
        check("w_nadr", n_adr, 32'hC010_0000);
        check("w_ndat", n_wdat, 32'h1234_5678);
        check("w_nsel", {28'd0, n_sel}, 32'hF);
        repeat (4) tick();
        check("w_hold", {31'd0, n_cyc}, 32'd1);
        check("w_noack", {28'd0, r_ack}, 32'd0);
        n_ack = 1'b1;
        settle();
        check("w_ack", {28'd0, r_ack}, 32'h1);
        tick();
        n_ack = 1'b0;
        settle();
        check("w_ncyc_drop", {31'd0, n_cyc}, 32'd0);
        check("w_ack_held", {28'd0, r_ack}, 32'h1);
        drop_req(0);
        settle();
        check("w_ack_rel", {28'd0, r_ack}, 32'd0);
        tick();
        check("w_gnt_clr", {28'd0, gnt}, 32'd0);

        // All four request continuously; rr=0 gives grant order 1,2,3,0,1.
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 3'b000, 32'h1000_0000 + 32'(i * 16), 32'd0);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("rr_gnt", {28'd0, gnt}, 32'd1 << order[k]);
            check("rr_adr", n_adr, 32'h1000_0000 + 32'(order[k] * 16));
            n_ack  = 1'b1;
            n_rdat = 32'h5500_0000 + 32'(k);
            settle();
            check("rr_ack", {28'd0, r_ack}, 32'd1 << order[k]);
            check("rr_dat", r_rdat, 32'h5500_0000 + 32'(k));
            tick();
            n_ack = 1'b0;
            r_stb = r_stb & ~(4'b0001 << order[k]);
            tick();
            check("rr_idle", {31'd0, n_cyc}, 32'd0);
            r_stb = r_stb | (4'b0001 << order[k]);
        end
        for (int i = 0; i < NREQ; i++) drop_req(i);

        // Burst read req2 tag 5, then aack routed to req2, then a stray aack.
        set_req(2, 1'b0, 3'b111, 32'h2000_0005, 32'd0);
        tick();
        check("b_gnt", {28'd0, gnt}, 32'h4);
        do_ack(2);
        n_aack = 1'b1; n_atag = 4'd5; n_rdat = 32'hCAFE_BABE;
        settle();
        check("b_aack",  {28'd0, r_aack}, 32'h4);
        check("b_adat",  r_rdat, 32'hCAFE_BABE);
        check("b_atag",  {28'd0, r_atag}, 32'd5);
        check("b_nostray", {31'd0, stray}, 32'd0);
        tick();
        n_aack = 1'b0;
        settle();
        check("b_pulse", {28'd0, r_aack}, 32'd0);
        n_aack = 1'b1;
        settle();
        check("b_stray", {31'd0, stray}, 32'd1);
        check("b_stray_aack", {28'd0, r_aack}, 32'd0);
        tick();
        n_aack = 1'b0;

        // Tag 5 owned by req2 blocks req1's burst to tag 5; req3 still served.
        set_req(2, 1'b0, 3'b111, 32'h2000_0015, 32'd0);
        tick();
        check("t_gnt2", {28'd0, gnt}, 32'h4);
        do_ack(2);
        set_req(1, 1'b0, 3'b001, 32'h3000_0005, 32'd0);
        tick();
        tick();
        check("t_blocked", {28'd0, gnt}, 32'd0);
        set_req(3, 1'b0, 3'b000, 32'h4000_0000, 32'd0);
        tick();
        check("t_gnt3", {28'd0, gnt}, 32'h8);
        do_ack(3);
        tick();
        check("t_still_blocked", {28'd0, gnt}, 32'd0);
        n_aack = 1'b1; n_atag = 4'd5; n_rdat = 32'h1111_2222;
        settle();
        check("t_aack2", {28'd0, r_aack}, 32'h4);
        tick();
        n_aack = 1'b0;
        check("t_gnt_wait", {28'd0, gnt}, 32'd0);
        tick();
        check("t_gnt1", {28'd0, gnt}, 32'h2);
        do_ack(1);

        // Sync ack coinciding with aack: aack data wins, ack follows one cycle later.
        set_req(0, 1'b0, 3'b000, 32'h5000_0000, 32'd0);
        tick();
        check("c_gnt0", {28'd0, gnt}, 32'h1);
        n_ack = 1'b1; n_aack = 1'b1; n_atag = 4'd5; n_rdat = 32'hDEAD_BEEF;
        settle();
        check("c_aack1", {28'd0, r_aack}, 32'h2);
        check("c_adat",  r_rdat, 32'hDEAD_BEEF);
        check("c_ack_delayed", {28'd0, r_ack}, 32'd0);
        tick();
        n_ack = 1'b0; n_aack = 1'b0; n_rdat = 32'h0BAD_F00D;
        settle();
        check("c_hold", {31'd0, n_cyc}, 32'd1);
        check("c_ack", {28'd0, r_ack}, 32'h1);
        check("c_dat", r_rdat, 32'h0BAD_F00D);
        tick();
        drop_req(0);
        tick();

        // Timeout: no NIC response, err at cycle TMO, then req3 is next.
        set_req(2, 1'b1, 3'b000, 32'h6000_0000, 32'h0000_0077);
        set_req(3, 1'b0, 3'b000, 32'h7000_0000, 32'd0);
        tick();
        check("o_gnt2", {28'd0, gnt}, 32'h4);
        cyc_cnt = 0;
        while (r_err[2] !== 1'b1 && cyc_cnt < 2000) begin
            tick();
            cyc_cnt++;
        end
        check("o_cycles", 32'(cyc_cnt), 32'(TMO));
        check("o_err", {28'd0, r_err}, 32'h4);
        check("o_ncyc_before", {31'd0, n_cyc}, 32'd1);
        tick();
        check("o_ncyc_drop", {31'd0, n_cyc}, 32'd0);
        check("o_err_held", {28'd0, r_err}, 32'h4);
        drop_req(2);
        tick();
        tick();
        check("o_gnt3", {28'd0, gnt}, 32'h8);
        do_ack(3);

        // Reset while BUSY with an outstanding tag 9.
        set_req(2, 1'b0, 3'b111, 32'h2000_0009, 32'd0);
        tick();
        check("r_gnt2", {28'd0, gnt}, 32'h4);
        do_ack(2);
        set_req(0, 1'b0, 3'b000, 32'h8000_0000, 32'd0);
        set_req(1, 1'b0, 3'b000, 32'h9000_0000, 32'd0);
        tick();
        check("r_gnt0", {28'd0, gnt}, 32'h1);
        rst_n = 1'b0;
        settle();
        check("r_async_ncyc", {31'd0, n_cyc}, 32'd0);
        check("r_async_gnt",  {28'd0, gnt}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        n_aack = 1'b1; n_atag = 4'd9;
        settle();
        check("r_tbl_stray", {31'd0, stray}, 32'd1);
        check("r_tbl_aack",  {28'd0, r_aack}, 32'd0);
        tick();
        n_aack = 1'b0;
        check("r_first_gnt", {28'd0, gnt}, 32'h2);
        do_ack(1);
        drop_req(0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
